// File: rtl/operand_pkg.sv
// Shared types and default widths for the ALU operand-B datapath.
package operand_pkg;

  typedef enum logic [1:0] {
    SRC_REG    = 2'd0,
    SRC_INC    = 2'd1,
    SRC_IMM    = 2'd2,
    SRC_IMM_SH = 2'd3
  } alu_src_b_e;

  localparam int unsigned DefaultDataW    = 32;
  localparam int unsigned DefaultIncConst = 4;
  localparam int unsigned DefaultImmShift = 2;

endpackage

// File: rtl/operand_b_stage_if.sv
// Request/response bundle for operand_b_stage: slave is the stage, master is its driver.
interface operand_b_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            alu_src_b;
  logic [DATA_W-1:0]     reg_b;
  logic [REG_ADDR_W-1:0] reg_b_addr;
  logic [IMM_W-1:0]      imm;
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]     wb_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_W-1:0]     alu_in_b;
  logic [1:0]            out_sel;

  modport master (
    output in_valid, alu_src_b, reg_b, reg_b_addr, imm, wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, alu_in_b, out_sel
  );

  modport slave (
    input  in_valid, alu_src_b, reg_b, reg_b_addr, imm, wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, alu_in_b, out_sel
  );
endinterface

// File: rtl/operand_imm_ext.sv
// Combinational immediate builder: sign-extends the raw immediate and a left-shifted copy.
module operand_imm_ext
  import operand_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned IMM_W     = 16,
  parameter int unsigned IMM_SHIFT = DefaultImmShift
) (
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] imm_sext,
  output logic [DATA_W-1:0] imm_sext_sh
);

  // Size-casting a signed operand replicates its MSB, which also covers IMM_W == DATA_W.
  assign imm_sext    = DATA_W'($signed(imm));
  assign imm_sext_sh = imm_sext << IMM_SHIFT;

endmodule

// File: rtl/operand_b_stage.sv
// Registered ALU operand-B selector with a single-entry valid/ready output register.
// Optional writeback forwarding on the register source is enabled by defining OPB_BYPASS_EN.
module operand_b_stage
  import operand_pkg::*;
#(
  parameter int unsigned DATA_W     = DefaultDataW,
  parameter int unsigned IMM_W      = 16,
  parameter int unsigned INC_CONST  = DefaultIncConst,
  parameter int unsigned IMM_SHIFT  = DefaultImmShift,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic               clk,
  input logic               rst,
  operand_b_stage_if.slave  bus
);

  alu_src_b_e        sel;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_sext_sh;
  logic              bypass;
  logic              accept;
  logic [DATA_W-1:0] operand_d;
  logic [DATA_W-1:0] alu_in_b_q;
  alu_src_b_e        out_sel_q;
  logic              out_valid_q;

  assign sel = alu_src_b_e'(bus.alu_src_b);

  operand_imm_ext #(
    .DATA_W    (DATA_W),
    .IMM_W     (IMM_W),
    .IMM_SHIFT (IMM_SHIFT)
  ) u_imm_ext (
    .imm         (bus.imm),
    .imm_sext    (imm_sext),
    .imm_sext_sh (imm_sext_sh)
  );

`ifdef OPB_BYPASS_EN
  // Register 0 is hardwired, so a write to it must never be forwarded.
  assign bypass = (sel == SRC_REG) && bus.wb_en && (bus.wb_addr == bus.reg_b_addr) &&
                  (bus.wb_addr != '0);
`else
  logic unused_wb;
  assign unused_wb = ^{bus.wb_en, bus.wb_addr, bus.wb_data, bus.reg_b_addr};
  assign bypass    = 1'b0;
`endif

  always_comb begin
    operand_d = bus.reg_b;
    unique case (sel)
      SRC_REG:    operand_d = bypass ? bus.wb_data : bus.reg_b;
      SRC_INC:    operand_d = DATA_W'(INC_CONST);
      SRC_IMM:    operand_d = imm_sext;
      SRC_IMM_SH: operand_d = imm_sext_sh;
      default:    operand_d = bus.reg_b;
    endcase
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_in_b_q  <= '0;
      out_sel_q   <= SRC_REG;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      alu_in_b_q  <= operand_d;
      out_sel_q   <= sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.alu_in_b  = alu_in_b_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_operand_b_stage.sv
// Scoreboard bench for operand_b_stage: directed plan items plus random handshake traffic.
module tb_operand_b_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  operand_b_stage_if #(.DATA_W(32), .IMM_W(16), .REG_ADDR_W(5)) bus ();
  operand_b_stage_if #(.DATA_W(16), .IMM_W(8),  .REG_ADDR_W(5)) bus2 ();

  operand_b_stage #(
    .DATA_W(32), .IMM_W(16), .INC_CONST(4), .IMM_SHIFT(2), .REG_ADDR_W(5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  operand_b_stage #(
    .DATA_W(16), .IMM_W(8), .INC_CONST(4), .IMM_SHIFT(1), .REG_ADDR_W(5)
  ) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: operand value from the select rules using plain integer arithmetic.
  function automatic longint unsigned ref_op(int dw, int iw, int sh, int inc, int sel,
                                             longint unsigned rb, longint unsigned im,
                                             bit byp, longint unsigned wd);
    longint mask, s;
    mask = (longint'(1) << dw) - 1;
    s = (im >= (longint'(1) << (iw - 1))) ? longint'(im) - (longint'(1) << iw) : longint'(im);
    case (sel)
      0:       return byp ? (wd & mask) : (rb & mask);
      1:       return longint'(inc) & mask;
      2:       return s & mask;
      default: return (s * (longint'(1) << sh)) & mask;
    endcase
  endfunction

  function automatic bit ref_bypass(int sel, bit en, int waddr, int raddr);
`ifdef OPB_BYPASS_EN
    return (sel == 0) && en && (waddr == raddr) && (waddr != 0);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [63:0] data;
    logic [1:0]  sel;
  } exp_t;

  exp_t        sb_q[$];
  bit          mon_en  = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_rdy, m_acc;
  exp_t        e;

  // Predictor + checker: sampled mid-cycle, inputs are stable for the next rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      m_rdy = !m_valid || bus.out_ready;
      check("in_ready", 64'(bus.in_ready), 64'(m_rdy));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      if (m_valid) begin
        if (sb_q.size() == 0) check("sb_underflow", 64'(sb_q.size()), 64'd1);
        else begin
          check("alu_in_b", 64'(bus.alu_in_b), sb_q[0].data);
          check("out_sel", 64'(bus.out_sel), 64'(sb_q[0].sel));
        end
      end
      if (rst) begin
        sb_q.delete();
        m_valid = 1'b0;
      end else begin
        m_acc = bus.in_valid && m_rdy;
        if (m_valid && bus.out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
        if (m_acc) begin
          e.data = ref_op(32, 16, 2, 4, int'(bus.alu_src_b), 64'(bus.reg_b), 64'(bus.imm),
                          ref_bypass(int'(bus.alu_src_b), bus.wb_en, int'(bus.wb_addr),
                                     int'(bus.reg_b_addr)),
                          64'(bus.wb_data));
          e.sel  = bus.alu_src_b;
          sb_q.push_back(e);
        end
        m_valid = m_acc || (m_valid && !bus.out_ready);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] rb,
                       input logic [15:0] im, input logic rdy);
    bus.in_valid  = v;
    bus.alu_src_b = s;
    bus.reg_b     = rb;
    bus.imm       = im;
    bus.out_ready = rdy;
  endtask

  logic [63:0] exp_byp;

  initial begin
    drive(1'b0, 2'd0, 32'd0, 16'd0, 1'b1);
    bus.reg_b_addr = '0;
    bus.wb_en      = 1'b0;
    bus.wb_addr    = '0;
    bus.wb_data    = '0;
    bus2.in_valid   = 1'b0;
    bus2.alu_src_b  = 2'd0;
    bus2.reg_b      = '0;
    bus2.reg_b_addr = '0;
    bus2.imm        = '0;
    bus2.wb_en      = 1'b0;
    bus2.wb_addr    = '0;
    bus2.wb_data    = '0;
    bus2.out_ready  = 1'b1;

    step();
    mon_en = 1'b1;
    step();
    rst = 1'b0;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_alu_in_b", 64'(bus.alu_in_b), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Select sweep at full throughput.
    drive(1'b1, 2'd0, 32'h1234_5678, 16'h0000, 1'b1);
    step();
    check("sweep_sel0", 64'(bus.alu_in_b), 64'h1234_5678);
    drive(1'b1, 2'd1, 32'h1234_5678, 16'h0000, 1'b1);
    step();
    check("sweep_sel1", 64'(bus.alu_in_b), 64'h0000_0004);
    drive(1'b1, 2'd2, 32'h0, 16'hFFFC, 1'b1);
    step();
    check("sweep_sel2", 64'(bus.alu_in_b), 64'hFFFF_FFFC);
    check("sweep_nobubble", 64'(bus.out_valid), 64'd1);
    drive(1'b1, 2'd3, 32'h0, 16'h8001, 1'b1);
    step();
    check("sweep_sel3", 64'(bus.alu_in_b), 64'hFFFE_0004);
    check("sweep_out_sel3", 64'(bus.out_sel), 64'd3);
    drive(1'b0, 2'd0, 32'h0, 16'h0, 1'b1);
    step();

    // Back-pressure: held operand stays put while inputs churn.
    drive(1'b1, 2'd0, 32'hAAAA_0000, 16'h0, 1'b0);
    step();
    drive(1'b1, 2'd1, 32'h5555_1234, 16'h7777, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      step();
      check("bp_alu_in_b", 64'(bus.alu_in_b), 64'hAAAA_0000);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);
    step();
    check("bp_next_loaded", 64'(bus.alu_in_b), 64'h0000_0004);
    drive(1'b0, 2'd0, 32'h0, 16'h0, 1'b1);
    step();

    // Select-only change without a request.
    bus.alu_src_b = 2'd3;
    step();
    check("selonly_alu_in_b", 64'(bus.alu_in_b), 64'h0000_0004);
    check("selonly_out_sel", 64'(bus.out_sel), 64'd1);

    // Writeback forwarding.
    drive(1'b1, 2'd0, 32'h1, 16'h0, 1'b1);
    bus.reg_b_addr = 5'd7;
    bus.wb_en      = 1'b1;
    bus.wb_addr    = 5'd7;
    bus.wb_data    = 32'hDEAD_BEEF;
`ifdef OPB_BYPASS_EN
    exp_byp = 64'hDEAD_BEEF;
`else
    exp_byp = 64'h1;
`endif
    step();
    check("bypass_addr7", 64'(bus.alu_in_b), exp_byp);
    bus.reg_b_addr = 5'd0;
    bus.wb_addr    = 5'd0;
    step();
    check("bypass_addr0", 64'(bus.alu_in_b), 64'h1);
    bus.in_valid = 1'b0;
    bus.wb_en    = 1'b0;
    step();

    // Reset while an operand is held under back-pressure.
    drive(1'b1, 2'd0, 32'h77, 16'h0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    step();
    check("rst_during_ready", 64'(bus.in_ready), 64'd1);
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_alu_in_b", 64'(bus.alu_in_b), 64'd0);
    check("rst_out_sel", 64'(bus.out_sel), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    step();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bus.in_valid   = ($urandom_range(0, 9) < 7);
      bus.out_ready  = ($urandom_range(0, 9) < 6);
      bus.alu_src_b  = 2'($urandom_range(0, 3));
      bus.reg_b      = $urandom;
      bus.imm        = 16'($urandom);
      bus.reg_b_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.wb_en      = $urandom_range(0, 1) == 1;
      bus.wb_addr    = $urandom_range(0, 1) == 1 ? bus.reg_b_addr : 5'($urandom);
      bus.wb_data    = $urandom;
      rst            = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 16'h0, 1'b1);
    bus.wb_en = 1'b0;
    repeat (3) step();
    check("drain_sb_empty", 64'(sb_q.size()), 64'd0);

    // Narrow build: DATA_W=16, IMM_W=8, IMM_SHIFT=1.
    bus2.alu_src_b = 2'd3;
    bus2.imm       = 8'hC0;
    bus2.in_valid  = 1'b1;
    step();
    check("narrow_sel3_c0", 64'(bus2.alu_in_b), 64'hFF80);
    for (int i = 0; i < 24; i++) begin
      bus2.alu_src_b = 2'($urandom_range(0, 3));
      bus2.imm       = 8'($urandom);
      bus2.reg_b     = 16'($urandom);
      step();
      check("narrow_rand", 64'(bus2.alu_in_b),
            ref_op(16, 8, 1, 4, int'(bus2.alu_src_b), 64'(bus2.reg_b), 64'(bus2.imm), 1'b0,
                   64'd0));
    end
    bus2.in_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_b_stage.md
# operand_b_stage

Registered, parametrised ALU operand-B selector for the multicycle datapath. It accepts a source select, a register-file read value and a raw immediate, and builds the sign-extended and shifted immediates internally. It places the chosen operand in an output register behind a valid/ready handshake and can optionally forward a same-cycle writeback value. It sits between the register-file read stage and the ALU, replacing the unregistered four-way operand-B mux.

## Interface
- DATA_W, 32, operand width
- IMM_W, 16, raw immediate width (IMM_W <= DATA_W)
- INC_CONST, 4, constant driven on select 1 (PC increment)
- IMM_SHIFT, 2, left-shift applied to the sign-extended immediate on select 3
- REG_ADDR_W, 5, register address width
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  request valid
- in_ready  output  1  stage can accept
- alu_src_b  input  2  source select
- reg_b  input  DATA_W  register-file port-B value
- reg_b_addr  input  REG_ADDR_W  register address of reg_b
- imm  input  IMM_W  raw immediate
- wb_en  input  1  writeback strobe (used only with OPB_BYPASS_EN)
- wb_addr  input  REG_ADDR_W  writeback address (used only with OPB_BYPASS_EN)
- wb_data  input  DATA_W  writeback data (used only with OPB_BYPASS_EN)
- out_valid  output  1  alu_in_b holds a valid operand
- out_ready  input  1  ALU consumes operand
- alu_in_b  output  DATA_W  registered operand B
- out_sel  output  2  registered copy of the accepted alu_src_b

## Operation
- Select decode:
  - 0: reg_b
  - 1: INC_CONST, zero-extended or truncated to DATA_W
  - 2: sext(imm) to DATA_W
  - 3: (sext(imm) << IMM_SHIFT), truncated to DATA_W; vacated LSBs are 0
- All four select codes are legal; there is no default or error path.
- Single-entry output register.
- in_ready = !out_valid || out_ready (combinational).
- Accept happens when in_valid && in_ready: alu_in_b and out_sel load, and out_valid is set.
- Drain happens when out_valid && out_ready && !accept: out_valid clears. alu_in_b keeps its last value.
- Simultaneous drain and accept: the new operand loads on the same edge and out_valid stays 1, giving full throughput of one operand per cycle.
- Back-pressure: while out_valid && !out_ready, alu_in_b and out_sel are stable and in_ready = 0.
- Inputs are sampled only on accept. Changes to alu_src_b alone never alter alu_in_b; this fixes the select-only sensitivity of the old mux.

## Timing
- Latency: 1 cycle, accept edge to out_valid = 1.
- Reset values: out_valid = 0, alu_in_b = 0, out_sel = 0. in_ready = 1 during and after reset.
- rst has priority over accept and drain. A held, unconsumed operand is discarded; there is no replay.
- No combinational path from in_valid or data inputs to out_valid or alu_in_b.
- The only combinational input-to-output path is out_ready -> in_ready.

## Configuration
- Macro: OPB_BYPASS_EN.
- Defined, bypass condition: alu_src_b == 0 && wb_en && wb_addr == reg_b_addr && wb_addr != 0, evaluated in the accept cycle.
- When the bypass condition holds, wb_data is loaded instead of reg_b.
- Address 0 is never bypassed.
- Undefined: wb_en, wb_addr and wb_data are ignored and select 0 always loads reg_b. The ports remain present.

## Structure
- Shared package, operand_pkg:
  - enum alu_src_b_e: SRC_REG = 0, SRC_INC = 1, SRC_IMM = 2, SRC_IMM_SH = 3
  - default values for DATA_W, INC_CONST and IMM_SHIFT
- One sub-module, operand_imm_ext: a combinational sign-extend and shift. Parameters DATA_W, IMM_W and IMM_SHIFT; outputs imm_sext and imm_sext_sh.
- The top level holds the select mux, the bypass compare and the output register.

## Test plan
- Reset: assert rst for 2 cycles mid-transfer, with out_valid = 1 and out_ready = 0 -> out_valid = 0, alu_in_b = 0, in_ready = 1 on the cycle after reset.
- Select sweep, out_ready held 1:
  - sel 0, reg_b = 0x12345678 -> 0x12345678
  - sel 1 -> 0x00000004
  - sel 2, imm = 0xFFFC -> 0xFFFFFFFC
  - sel 3, imm = 0x8001 -> 0xFFFE0004
  - each result appears 1 cycle after accept, one per cycle, no bubbles
- Back-pressure: accept 0xAAAA0000, hold out_ready = 0 for 3 cycles while changing reg_b and sel -> alu_in_b stays 0xAAAA0000 and in_ready = 0. Release -> next operand accepted on the drain edge.
- Select-only change: with in_valid = 0, toggle alu_src_b 0 -> 3 -> alu_in_b and out_sel unchanged.
- Bypass, macro defined: sel 0, reg_b_addr = 7, reg_b = 0x1, wb_en = 1, wb_addr = 7, wb_data = 0xDEADBEEF -> 0xDEADBEEF. Same with addr 0 -> 0x1. Same with macro undefined -> 0x1.
- Parameter build: DATA_W = 16, IMM_W = 8, IMM_SHIFT = 1, sel 3, imm = 0xC0 -> 0xFF80.
